// File: rtl/letter_decoder_pkg.sv
// letter_decoder_pkg: letter code constants, FSM state encoding and the code-to-strobe decode.
package letter_decoder_pkg;
    typedef logic [3:0] code_t;
    typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;
    localparam code_t CODE_A = 4'b1010;
    localparam code_t CODE_B = 4'b1011;
    localparam code_t CODE_C = 4'b1100;
    localparam code_t CODE_D = 4'b1101;
    localparam code_t CODE_E = 4'b1110;
    localparam code_t CODE_F = 4'b1111;
    localparam int N_TALLY = 6;
    // One-hot result ordered {err, F, D, C, B, A}; every code below CODE_A is an error.
    function automatic logic [N_TALLY-1:0] decode(code_t c);
        return {c == CODE_E || c < CODE_A, c == CODE_F, c == CODE_D, c == CODE_C, c == CODE_B, c == CODE_A};
    endfunction
endpackage

// File: rtl/letter_decoder_if.sv
// letter_decoder_if: valid/ready letter-code handshake between the code producer and the decoder.
interface letter_decoder_if;
    import letter_decoder_pkg::*;
    code_t code;
    logic valid;
    logic ready;
    modport master(output code, output valid, input ready);
    modport slave(input code, input valid, output ready);
endinterface

// File: rtl/letter_decoder_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset || clr) q <= '0;
        else if (inc && q != {W{1'b1}}) q <= q + W'(1);
    end
endmodule

// File: rtl/letter_decoder.sv
// letter_decoder: decodes accepted letter codes into one-hot strobes held for HOLD_CYCLES,
// keeping a saturating tally per letter plus errors.
module letter_decoder
    import letter_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset,
    letter_decoder_if.slave bus,
    input  logic clear_counts,
    output logic outA,
    output logic outB,
    output logic outC,
    output logic outD,
    output logic outF,
    output logic err,
    output logic out_valid,
    output logic [CNT_W-1:0] cntA,
    output logic [CNT_W-1:0] cntB,
    output logic [CNT_W-1:0] cntC,
    output logic [CNT_W-1:0] cntD,
    output logic [CNT_W-1:0] cntF,
    output logic [CNT_W-1:0] cntErr
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    state_t state, state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [N_TALLY-1:0] shown, dec;
    logic accept, hold_done;
    logic [CNT_W-1:0] cnt [N_TALLY];

    always_comb begin
        dec = decode(bus.code);
        accept = bus.valid && state == IDLE;
        hold_done = hold_cnt == '0;
        state_nxt = state == IDLE ? (accept ? SHOW : IDLE) : (hold_done ? IDLE : SHOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hold_cnt <= '0;
            shown <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hold_cnt <= HW'(HOLD_CYCLES - 1);
                shown <= dec;
            end else if (state == SHOW) begin
                hold_cnt <= hold_cnt - HW'(1);
                shown <= hold_done ? '0 : shown;
            end
        end
    end

    assign bus.ready = state == IDLE;
    assign out_valid = state == SHOW;
    assign {err, outF, outD, outC, outB, outA} = shown;

    // A clear on the accept edge beats the increment inside each counter.
    for (genvar i = 0; i < N_TALLY; i++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk(clk),
            .reset(reset),
            .clr(clear_counts),
            .inc(accept && dec[i]),
            .q(cnt[i])
        );
    end

    assign {cntErr, cntF, cntD, cntC, cntB, cntA} = {cnt[5], cnt[4], cnt[3], cnt[2], cnt[1], cnt[0]};
endmodule

// File: tb/tb_letter_decoder.sv
// tb_letter_decoder: scoreboard bench; dut0 uses HOLD_CYCLES=4/CNT_W=2, dut1 HOLD_CYCLES=1/CNT_W=8.
module tb_letter_decoder;
    typedef struct {
        logic [5:0] hot;
        logic [11:0] cnt;
    } exp_t;

    logic clk = 0;
    logic reset = 1;
    logic clear_counts = 0;
    logic clear1 = 0;
    always #5 clk = ~clk;

    letter_decoder_if bus0();
    letter_decoder_if bus1();

    logic outA, outB, outC, outD, outF, err, out_valid;
    logic [1:0] cntA, cntB, cntC, cntD, cntF, cntErr;
    logic b_outA, b_outB, b_outC, b_outD, b_outF, b_err, b_out_valid;
    logic [7:0] b_cntA, b_cntB, b_cntC, b_cntD, b_cntF, b_cntErr;

    letter_decoder #(.HOLD_CYCLES(4), .CNT_W(2)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .clear_counts(clear_counts),
        .outA(outA), .outB(outB), .outC(outC), .outD(outD), .outF(outF), .err(err), .out_valid(out_valid),
        .cntA(cntA), .cntB(cntB), .cntC(cntC), .cntD(cntD), .cntF(cntF), .cntErr(cntErr)
    );

    letter_decoder #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .clear_counts(clear1),
        .outA(b_outA), .outB(b_outB), .outC(b_outC), .outD(b_outD), .outF(b_outF), .err(b_err), .out_valid(b_out_valid),
        .cntA(b_cntA), .cntB(b_cntB), .cntC(b_cntC), .cntD(b_cntD), .cntF(b_cntF), .cntErr(b_cntErr)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mc [6];
    exp_t sb [$];
    exp_t got;
    logic prev_v = 0;

    wire [5:0] hot = {err, outF, outD, outC, outB, outA};
    wire [11:0] cnts = {cntErr, cntF, cntD, cntC, cntB, cntA};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] ref_hot(input logic [3:0] c);
        case (c)
            4'ha: return 6'b000001;
            4'hb: return 6'b000010;
            4'hc: return 6'b000100;
            4'hd: return 6'b001000;
            4'hf: return 6'b010000;
            default: return 6'b100000;
        endcase
    endfunction

    // Each rising out_valid on dut0 must match the oldest accepted code and tallies.
    always @(negedge clk) begin
        if (out_valid && !prev_v) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL mon_unexpected_display hot=%b cnt=%h, no pending accept", hot, cnts);
            end else begin
                got = sb.pop_front();
                if (hot !== got.hot || cnts !== got.cnt) begin
                    bad++;
                    $display("FAIL mon_display hot=%b cnt=%h want hot=%b cnt=%h", hot, cnts, got.hot, got.cnt);
                end
            end
        end
        prev_v = out_valid;
    end

    task automatic send(input logic [3:0] c, input logic clr, output int acc);
        exp_t e;
        int n = 0;
        logic [5:0] h;
        bus0.code = c;
        bus0.valid = 1;
        clear_counts = clr;
        while (!bus0.ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (clr) foreach (mc[i]) mc[i] = 0;
        end
        total++;
        if (bus0.ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready_timeout ready=%b want 1", bus0.ready);
            bus0.valid = 0;
            clear_counts = 0;
            acc = -1;
            return;
        end
        h = ref_hot(c);
        for (int i = 0; i < 6; i++) begin
            if (clr) mc[i] = 0;
            else if (h[i] && mc[i] < 3) mc[i]++;
        end
        e.hot = h;
        for (int i = 0; i < 6; i++) e.cnt[2*i +: 2] = 2'(mc[i]);
        sb.push_back(e);
        @(posedge clk);
        #1;
        acc = cyc;
        bus0.valid = 0;
        clear_counts = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        foreach (mc[i]) mc[i] = 0;
        total++;
        if (bus0.ready !== 1'b1 || out_valid !== 1'b0 || hot !== 6'b0 || cnts !== 12'b0) begin
            bad++;
            $display("FAIL reset_dut0 ready=%b valid=%b hot=%b cnt=%h want 1 0 0 0", bus0.ready, out_valid, hot, cnts);
        end
        total++;
        if (bus1.ready !== 1'b1 || b_out_valid !== 1'b0 || {b_err, b_outF, b_outD, b_outC, b_outB, b_outA} !== 6'b0
            || {b_cntErr, b_cntF, b_cntD, b_cntC, b_cntB, b_cntA} !== 48'b0) begin
            bad++;
            $display("FAIL reset_dut1 ready=%b valid=%b want 1 0 and zero strobes/counts", bus1.ready, b_out_valid);
        end
    endtask

    task automatic test_single_a;
        int acc;
        send(4'ha, 0, acc);
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (outA !== 1'b1 || out_valid !== 1'b1 || bus0.ready !== 1'b0 || cntA !== 2'd1 || hot !== 6'b000001) begin
                bad++;
                $display("FAIL single_a_cycle%0d outA=%b valid=%b ready=%b cntA=%0d want 1 1 0 1", k, outA, out_valid, bus0.ready, cntA);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (bus0.ready !== 1'b1 || out_valid !== 1'b0 || outA !== 1'b0) begin
            bad++;
            $display("FAIL single_a_release ready=%b valid=%b outA=%b want 1 0 0", bus0.ready, out_valid, outA);
        end
    endtask

    task automatic test_errors;
        int a0, a1, a2;
        send(4'he, 0, a0);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_code_e err=%b want 1", err); end
        send(4'h5, 0, a1);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_code_5 err=%b want 1", err); end
        send(4'hf, 0, a2);
        total++;
        if (outF !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL code_f outF=%b err=%b want 1 0", outF, err); end
        total++;
        if (a1 - a0 != 5 || a2 - a1 != 5) begin
            bad++;
            $display("FAIL accept_spacing gaps=%0d,%0d want 5,5", a1 - a0, a2 - a1);
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (cntErr !== 2'd2 || cntF !== 2'd1) begin
            bad++;
            $display("FAIL err_tallies cntErr=%0d cntF=%0d want 2 1", cntErr, cntF);
        end
    endtask

    task automatic test_saturate;
        int acc;
        int want [5] = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            send(4'hc, 0, acc);
            total++;
            if (cntC !== 2'(want[i]) || outC !== 1'b1) begin
                bad++;
                $display("FAIL saturate_%0d cntC=%0d outC=%b want %0d 1", i, cntC, outC, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int acc;
        send(4'hb, 0, acc);
        @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        foreach (mc[i]) mc[i] = 0;
        total++;
        if (bus0.ready !== 1'b1 || outB !== 1'b0 || out_valid !== 1'b0 || cntB !== 2'd0 || cnts !== 12'b0) begin
            bad++;
            $display("FAIL reset_mid ready=%b outB=%b valid=%b cntB=%0d cnt=%h want 1 0 0 0 0", bus0.ready, outB, out_valid, cntB, cnts);
        end
    endtask

    task automatic test_clear_accept;
        int acc;
        send(4'hd, 0, acc);
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (cntD !== 2'd1) begin bad++; $display("FAIL clear_pre cntD=%0d want 1", cntD); end
        send(4'hd, 1, acc);
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (outD !== 1'b1 || out_valid !== 1'b1 || cntD !== 2'd0) begin
                bad++;
                $display("FAIL clear_accept_cycle%0d outD=%b valid=%b cntD=%0d want 1 1 0", k, outD, out_valid, cntD);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (outD !== 1'b0 || cntD !== 2'd0 || bus0.ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_after outD=%b cntD=%0d ready=%b want 0 0 1", outD, cntD, bus0.ready);
        end
    endtask

    task automatic test_back_to_back;
        bus1.code = 4'ha;
        bus1.valid = 1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (b_out_valid !== 1'(k % 2) || b_outA !== 1'(k % 2) || bus1.ready !== 1'(1 - k % 2) || b_cntA !== 8'((k + 1) / 2)) begin
                bad++;
                $display("FAIL b2b_edge%0d valid=%b outA=%b ready=%b cntA=%0d want %0d %0d %0d %0d",
                         k, b_out_valid, b_outA, bus1.ready, b_cntA, k % 2, k % 2, 1 - k % 2, (k + 1) / 2);
            end
        end
        bus1.valid = 0;
    endtask

    initial begin
        bus0.code = 0;
        bus0.valid = 0;
        bus1.code = 0;
        bus1.valid = 0;
        test_reset();
        test_single_a();
        test_errors();
        test_saturate();
        test_reset_mid();
        test_clear_accept();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover pending=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit reached", $time);
        $fatal(1, "timeout");
    end
endmodule
